vote_ballot_encoder: RTL and testbench
======================================

// Module: vote_ballot_encoder
// PURPOSE
//  Producer side of the np/vip/vvip ballot bus consumed by the VoterPlus tally.
//  Accepts individual voter events over a valid/ready stream and keeps a cumulative shadow of every voter's opinion.
//  Publishes the shadow as a stable {np,vip,vvip} ballot with an out_valid/out_ready handshake, batch by batch.
// PARAMETERS
//  NP_W   32  number of normal voters (np width), <=32
//  VIP_W  8   number of VIP voters (vip width), <=32
//  BATCH  16  accepted applied events that force an automatic publish, 1..31
//  ERR_W  8   width of saturating error counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  in_valid   in   1      voter event present
//  in_ready   out  1      encoder can take an event
//  in_class   in   2      0=normal 1=vip 2=vvip 3=reserved
//  in_id      in   5      voter index within class
//  in_vote    in   1      1=vote yes, 0=retract
//  commit     in   1      request publish of the current batch
//  np         out  NP_W   published normal-voter ballot
//  vip        out  VIP_W  published VIP ballot
//  vvip       out  1      published VVIP ballot
//  out_valid  out  1      ballot valid, held until out_ready
//  out_ready  in   1      downstream accepts ballot
//  seq        out  8      count of completed publishes, wraps 255->0
//  err_cnt    out  ERR_W  rejected events, saturates at all-ones
// BEHAVIOUR
//  - reset low: np/vip/vvip=0, shadow=0, out_valid=0, seq=0, err_cnt=0, batch count=0, state IDLE. Applies immediately, also mid-PUBLISH.
//  - Accept = in_valid & in_ready at a rising edge. Shadow bit is set or cleared per in_vote on that edge.
//  - Invalid event: class 3, normal id>=NP_W, vip id>=VIP_W, or vvip id!=0.
//    It is accepted by the handshake, not applied, does not count toward BATCH, and increments err_cnt (saturating).
//  - Shadow is cumulative across batches. Retract of an already-0 bit is legal and counts as applied.
//  - FSM IDLE:
//    - in_ready=1.
//    - An applied event moves to COLLECT with count=1.
//    - commit with no applied event is ignored. An empty ballot is never published.
//  - FSM COLLECT:
//    - in_ready=1; each applied event increments count.
//    - Moves to PUBLISH when commit=1, or when an event brings count to BATCH.
//    - An event accepted on the same edge as commit is included in the batch.
//  - FSM PUBLISH:
//    - On entry edge, np/vip/vvip are loaded from shadow (including that edge's event) and out_valid=1.
//    - in_ready=0.
//    - np/vip/vvip are held stable while out_valid=1 and out_ready=0.
//    - On out_valid & out_ready: seq++, count=0, out_valid=0 next cycle, return to IDLE.
//    - np/vip/vvip keep their last published value until the next publish.
//  - Latency: event+commit at edge k -> out_valid high after edge k; earliest next accept is the edge after the handshake.
//  - commit while in PUBLISH is ignored (not queued).
// CONFIGURATION
//  VOTE_DEDUP_EN defined:
//    - Per-batch "voted" mask, cleared on publish.
//    - A second event for the same voter within one batch is rejected: err_cnt++, not applied, not counted.
//  VOTE_DEDUP_EN undefined: no mask; the last event in the batch wins.
// STRUCTURE
//  - Package vote_pkg:
//    - CLS_NP/CLS_VIP/CLS_VVIP/CLS_RSVD 2-bit constants.
//    - FSM state encoding ST_IDLE/ST_COLLECT/ST_PUBLISH.
//  - Sub-module vote_event_decode (combinational):
//    - Inputs: class, id, vote.
//    - Outputs: one-hot write masks for np/vip/vvip plus an invalid flag.
// TESTING
//  - Reset: reset=0 at t=0 -> all outputs 0, in_ready=0 during reset. Release reset -> in_ready=1, out_valid=0.
//  - Events (0,12,1),(1,7,1),(2,0,1), then commit -> out_valid=1; np=32'h0000_1000, vip=8'h80, vvip=1.
//    out_ready=1 -> seq=1.
//  - Hold: out_ready=0 for 5 cycles -> outputs stable, in_ready=0, extra commit ignored.
//    Then retract (0,12,0)+commit -> np=0, vip=8'h80, vvip=1 retained.
//  - Errors: events (3,0,1), (1,9,1), (2,1,1) -> err_cnt=3, no state change.
//    err_cnt preset near max -> saturates at 8'hFF.
//  - Auto-publish: BATCH=16 applied events with no commit -> out_valid on the 16th accept.
//    256 publishes total -> seq wraps to 0.
//  - Reset mid-PUBLISH: out_valid=1, then reset=0 -> out_valid=0 immediately.
//    After release: shadow=0, publish of one event shows only that bit.
//    DEDUP_EN: (0,3,1),(0,3,0) in one batch -> err_cnt=1, np bit3=1.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared constants, event payload and FSM encoding for the np/vip/vvip ballot encoder.
package vote_pkg;

    localparam int unsigned CLS_W = 2;
    localparam int unsigned ID_W  = 5;
    localparam int unsigned SEQ_W = 8;

    localparam logic [CLS_W-1:0] CLS_NP   = 2'd0;
    localparam logic [CLS_W-1:0] CLS_VIP  = 2'd1;
    localparam logic [CLS_W-1:0] CLS_VVIP = 2'd2;
    localparam logic [CLS_W-1:0] CLS_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    typedef struct packed {
        logic [CLS_W-1:0] cls;
        logic [ID_W-1:0]  id;
        logic             vote;
    } vote_evt_t;

endpackage

// File: rtl/vote_event_decode.sv
// Combinational decode of one voter event into per-class one-hot write masks.
module vote_event_decode
    import vote_pkg::*;
#(
    parameter int unsigned NP_W  = 32,
    parameter int unsigned VIP_W = 8
) (
    input  logic [CLS_W-1:0] cls,
    input  logic [ID_W-1:0]  id,
    input  logic             vote,
    output logic [NP_W-1:0]  np_mask_c,
    output logic [VIP_W-1:0] vip_mask_c,
    output logic             vvip_mask_c,
    output logic             wr_bit_c,
    output logic             invalid_c
);

    always_comb begin
        np_mask_c   = '0;
        vip_mask_c  = '0;
        vvip_mask_c = 1'b0;
        invalid_c   = 1'b0;
        wr_bit_c    = vote;
        case (cls)
            CLS_NP: begin
                if (32'(id) < NP_W) np_mask_c = NP_W'(1) << id;
                else                invalid_c = 1'b1;
            end
            CLS_VIP: begin
                if (32'(id) < VIP_W) vip_mask_c = VIP_W'(1) << id;
                else                 invalid_c  = 1'b1;
            end
            CLS_VVIP: begin
                if (id == ID_W'(0)) vvip_mask_c = 1'b1;
                else                invalid_c   = 1'b1;
            end
            CLS_RSVD: invalid_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/vote_ballot_encoder.sv
// Collects voter events into a cumulative shadow and publishes it batch by batch as a held ballot.
// Optional VOTE_DEDUP_EN: rejects a second event for the same voter within one batch.
module vote_ballot_encoder
    import vote_pkg::*;
#(
    parameter int unsigned NP_W  = 32,
    parameter int unsigned VIP_W = 8,
    parameter int unsigned BATCH = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CLS_W-1:0]  in_class,
    input  logic [ID_W-1:0]   in_id,
    input  logic              in_vote,
    input  logic              commit,
    output logic [NP_W-1:0]   np,
    output logic [VIP_W-1:0]  vip,
    output logic              vvip,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEQ_W-1:0]  seq,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int unsigned CNT_W = 5;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    vote_evt_t evt;
    state_t    state, state_nxt;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [NP_W-1:0]  sh_np, sh_np_nxt, np_mask_c;
    logic [VIP_W-1:0] sh_vip, sh_vip_nxt, vip_mask_c;
    logic             sh_vvip, sh_vvip_nxt, vvip_mask_c;
    logic             wr_bit_c, invalid_c, dup_c;
    logic             accept_c, applied_c, reject_c, load_c, handshake_c;

    assign evt = '{cls: in_class, id: in_id, vote: in_vote};

    vote_event_decode #(
        .NP_W  (NP_W),
        .VIP_W (VIP_W)
    ) u_decode (
        .cls         (evt.cls),
        .id          (evt.id),
        .vote        (evt.vote),
        .np_mask_c   (np_mask_c),
        .vip_mask_c  (vip_mask_c),
        .vvip_mask_c (vvip_mask_c),
        .wr_bit_c    (wr_bit_c),
        .invalid_c   (invalid_c)
    );

`ifdef VOTE_DEDUP_EN
    logic [NP_W-1:0]  voted_np;
    logic [VIP_W-1:0] voted_vip;
    logic             voted_vvip;

    assign dup_c = (|(np_mask_c & voted_np)) | (|(vip_mask_c & voted_vip)) |
                   (vvip_mask_c & voted_vvip);

    // Per-batch record of voters already heard from
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            voted_np   <= '0;
            voted_vip  <= '0;
            voted_vvip <= 1'b0;
        end else if (handshake_c) begin
            voted_np   <= '0;
            voted_vip  <= '0;
            voted_vvip <= 1'b0;
        end else if (applied_c) begin
            voted_np   <= voted_np | np_mask_c;
            voted_vip  <= voted_vip | vip_mask_c;
            voted_vvip <= voted_vvip | vvip_mask_c;
        end
    end
`else
    assign dup_c = 1'b0;
`endif

    assign accept_c  = in_valid & in_ready;
    assign reject_c  = accept_c & (invalid_c | dup_c);
    assign applied_c = accept_c & ~invalid_c & ~dup_c;

    // Shadow after this edge's event (set or clear the addressed bit)
    always_comb begin
        sh_np_nxt   = sh_np;
        sh_vip_nxt  = sh_vip;
        sh_vvip_nxt = sh_vvip;
        if (applied_c) begin
            sh_np_nxt   = (sh_np & ~np_mask_c) | ({NP_W{wr_bit_c}} & np_mask_c);
            sh_vip_nxt  = (sh_vip & ~vip_mask_c) | ({VIP_W{wr_bit_c}} & vip_mask_c);
            sh_vvip_nxt = (sh_vvip & ~vvip_mask_c) | (wr_bit_c & vvip_mask_c);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        load_c      = 1'b0;
        handshake_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (applied_c) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = (commit || cnt_nxt == CNT_W'(BATCH)) ? ST_PUBLISH : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (applied_c) cnt_nxt = cnt + CNT_W'(1);
                if (commit || (applied_c && cnt_nxt == CNT_W'(BATCH))) state_nxt = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                if (out_ready) begin
                    handshake_c = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        load_c = (state != ST_PUBLISH) && (state_nxt == ST_PUBLISH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            sh_np     <= '0;
            sh_vip    <= '0;
            sh_vvip   <= 1'b0;
            np        <= '0;
            vip       <= '0;
            vvip      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            seq       <= '0;
            err_cnt   <= '0;
        end else begin
            cnt       <= cnt_nxt;
            sh_np     <= sh_np_nxt;
            sh_vip    <= sh_vip_nxt;
            sh_vvip   <= sh_vvip_nxt;
            out_valid <= (state_nxt == ST_PUBLISH);
            in_ready  <= (state_nxt != ST_PUBLISH);
            if (load_c) begin
                np   <= sh_np_nxt;
                vip  <= sh_vip_nxt;
                vvip <= sh_vvip_nxt;
            end
            if (handshake_c) seq <= seq + SEQ_W'(1);
            if (reject_c && err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_vote_ballot_encoder.sv
// Self-checking bench for vote_ballot_encoder: directed table, corner sequences, random vs. model.
module tb_vote_ballot_encoder;

    localparam int unsigned NP_W  = 32;
    localparam int unsigned VIP_W = 8;
    localparam int unsigned BATCH = 16;
    localparam int unsigned ERR_W = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, in_vote, commit;
    logic [1:0]       in_class;
    logic [4:0]       in_id;
    logic [NP_W-1:0]  np;
    logic [VIP_W-1:0] vip;
    logic             vvip, out_valid, out_ready;
    logic [7:0]       seq;
    logic [ERR_W-1:0] err_cnt;

    always #5 clk = ~clk;

    vote_ballot_encoder #(
        .NP_W (NP_W), .VIP_W (VIP_W), .BATCH (BATCH), .ERR_W (ERR_W)
    ) dut (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_class (in_class), .in_id (in_id), .in_vote (in_vote),
        .commit (commit),
        .np (np), .vip (vip), .vvip (vvip),
        .out_valid (out_valid), .out_ready (out_ready),
        .seq (seq), .err_cnt (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-class voter arrays, a pending-ballot flag and a batch tally
    int  lim[3] = '{NP_W, VIP_W, 1};
    bit  m_sh[3][32];
    bit  m_pub[3][32];
    bit  m_voted[3][32];
    bit  m_busy, m_ready;
    int  m_cnt, m_seq, m_err;

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 32; i++) begin
                m_sh[c][i] = 0; m_pub[c][i] = 0; m_voted[c][i] = 0;
            end
        m_busy = 0; m_ready = 0; m_cnt = 0; m_seq = 0; m_err = 0;
    endtask

    task automatic model_edge(input int c, input int id, input bit v, input bit val,
                              input bit cm, input bit ordy);
        if (m_busy) begin
            if (ordy) begin
                m_busy = 0;
                m_seq  = (m_seq + 1) % 256;
                m_cnt  = 0;
                for (int k = 0; k < 3; k++)
                    for (int i = 0; i < 32; i++) m_voted[k][i] = 0;
            end
        end else begin
            if (val && m_ready) begin
                bit bad;
                if (c == 3) bad = 1;
                else        bad = (id >= lim[c]);
`ifdef VOTE_DEDUP_EN
                if (!bad && m_voted[c][id]) bad = 1;
`endif
                if (bad) m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                else begin
                    m_sh[c][id]    = v;
                    m_voted[c][id] = 1;
                    m_cnt++;
                end
            end
            if ((cm && m_cnt > 0) || m_cnt == BATCH) begin
                m_busy = 1;
                for (int k = 0; k < 3; k++)
                    for (int i = 0; i < 32; i++) m_pub[k][i] = m_sh[k][i];
            end
        end
        m_ready = !m_busy;
    endtask

    function automatic logic [31:0] mpack(input int c);
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) r[i] = m_pub[c][i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'(m_ready));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_busy));
        chk({tag, "_np"},        32'(np),        mpack(0));
        chk({tag, "_vip"},       32'(vip),       mpack(1));
        chk({tag, "_vvip"},      32'(vvip),      mpack(2));
        chk({tag, "_seq"},       32'(seq),       32'(m_seq));
        chk({tag, "_err_cnt"},   32'(err_cnt),   32'(m_err));
    endtask

    // One clock: drive after negedge, update model at posedge, leave at next negedge
    task automatic step(input logic [1:0] c, input logic [4:0] id, input logic v,
                        input logic val, input logic cm, input logic ordy);
        in_class = c; in_id = id; in_vote = v; in_valid = val; commit = cm; out_ready = ordy;
        @(posedge clk);
        model_edge(int'(c), int'(id), v, val, cm, ordy);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  c;
        logic [4:0]  id;
        logic        v, val, cm, ordy;
        logic        rdy, ov;
        logic [31:0] np;
        logic [7:0]  vip;
        logic        vvip;
        logic [7:0]  seq, err;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2'd0, 5'd12, 1, 1, 0, 0, 1, 0, 32'h0,       8'h00, 0, 8'd0, 8'd0};
        tbl[1]  = '{2'd1, 5'd7,  1, 1, 0, 0, 1, 0, 32'h0,       8'h00, 0, 8'd0, 8'd0};
        tbl[2]  = '{2'd2, 5'd0,  1, 1, 0, 0, 1, 0, 32'h0,       8'h00, 0, 8'd0, 8'd0};
        tbl[3]  = '{2'd0, 5'd0,  0, 0, 1, 0, 0, 1, 32'h1000,    8'h80, 1, 8'd0, 8'd0};
        tbl[4]  = '{2'd0, 5'd0,  0, 0, 0, 1, 1, 0, 32'h1000,    8'h80, 1, 8'd1, 8'd0};
        tbl[5]  = '{2'd2, 5'd0,  1, 1, 1, 0, 0, 1, 32'h1000,    8'h80, 1, 8'd1, 8'd0};
        for (int k = 6; k <= 10; k++)
            tbl[k] = '{2'd0, 5'd3, 1, 1, 1, 0, 0, 1, 32'h1000,  8'h80, 1, 8'd1, 8'd0};
        tbl[11] = '{2'd0, 5'd0,  0, 0, 0, 1, 1, 0, 32'h1000,    8'h80, 1, 8'd2, 8'd0};
        tbl[12] = '{2'd0, 5'd12, 0, 1, 1, 0, 0, 1, 32'h0,       8'h80, 1, 8'd2, 8'd0};
        tbl[13] = '{2'd0, 5'd0,  0, 0, 0, 1, 1, 0, 32'h0,       8'h80, 1, 8'd3, 8'd0};
        tbl[14] = '{2'd3, 5'd0,  1, 1, 1, 0, 1, 0, 32'h0,       8'h80, 1, 8'd3, 8'd1};
        tbl[15] = '{2'd1, 5'd9,  1, 1, 1, 0, 1, 0, 32'h0,       8'h80, 1, 8'd3, 8'd2};
        tbl[16] = '{2'd2, 5'd1,  1, 1, 1, 0, 1, 0, 32'h0,       8'h80, 1, 8'd3, 8'd3};

        // Reset state
        reset = 1'b0; in_valid = 0; in_class = 0; in_id = 0; in_vote = 0; commit = 0; out_ready = 0;
        model_reset();
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_np",        32'(np),        32'h0);
        chk("rst_seq",       32'(seq),       32'h0);
        chk("rst_err",       32'(err_cnt),   32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("rel_in_ready",  32'(in_ready),  32'h1);
        chk("rel_out_valid", 32'(out_valid), 32'h0);

        // Directed table: publish, hold, retract, invalid events
        for (int k = 0; k < 17; k++) begin
            step(tbl[k].c, tbl[k].id, tbl[k].v, tbl[k].val, tbl[k].cm, tbl[k].ordy);
            chk($sformatf("row%0d_in_ready", k),  32'(in_ready),  32'(tbl[k].rdy));
            chk($sformatf("row%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].ov));
            chk($sformatf("row%0d_np", k),        32'(np),        tbl[k].np);
            chk($sformatf("row%0d_vip", k),       32'(vip),       32'(tbl[k].vip));
            chk($sformatf("row%0d_vvip", k),      32'(vvip),      32'(tbl[k].vvip));
            chk($sformatf("row%0d_seq", k),       32'(seq),       32'(tbl[k].seq));
            chk($sformatf("row%0d_err", k),       32'(err_cnt),   32'(tbl[k].err));
        end

        // Error counter saturation
        for (int k = 0; k < 252; k++) step(3, 0, 1, 1, 0, 0);
        chk("err_at_max", 32'(err_cnt), 32'hFF);
        for (int k = 0; k < 3; k++) step(1, 31, 1, 1, 0, 0);
        chk("err_saturated", 32'(err_cnt), 32'hFF);
        check_model("sat");

        // Automatic publish on the BATCH-th applied event
        for (int k = 0; k < 16; k++) begin
            step(0, 5'(k), 1, 1, 0, 0);
            if (k == 14) chk("auto_not_yet", 32'(out_valid), 32'h0);
            if (k == 15) begin
                chk("auto_valid", 32'(out_valid), 32'h1);
                chk("auto_np",    32'(np),        32'h0000_FFFF);
            end
        end
        step(0, 0, 0, 0, 0, 1);
        chk("auto_seq", 32'(seq), 32'd4);

        // Sequence counter wrap after 256 publishes
        for (int k = 0; k < 252; k++) begin
            step(0, 0, 1, 1, 1, 1);
            step(0, 0, 0, 0, 0, 1);
        end
        chk("seq_wrap", 32'(seq), 32'h0);
        check_model("wrap");

        // Asynchronous reset while a ballot is pending
        step(0, 1, 1, 1, 1, 0);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        in_valid = 0; commit = 0; out_ready = 0;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_in_ready",  32'(in_ready),  32'h0);
        chk("midrst_np",        32'(np),        32'h0);
        chk("midrst_err",       32'(err_cnt),   32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        check_model("post_rst");
        step(1, 2, 1, 1, 1, 0);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_np",    32'(np),        32'h0);
        chk("single_vip",   32'(vip),       32'h04);
        chk("single_vvip",  32'(vvip),      32'h0);
        step(0, 0, 0, 0, 0, 1);
        chk("single_seq", 32'(seq), 32'h1);

        // Same voter twice in one batch
        step(0, 3, 1, 1, 0, 0);
        step(0, 3, 0, 1, 1, 0);
`ifdef VOTE_DEDUP_EN
        chk("dup_np",  32'(np),      32'h8);
        chk("dup_err", 32'(err_cnt), 32'h1);
`else
        chk("dup_np",  32'(np),      32'h0);
        chk("dup_err", 32'(err_cnt), 32'h0);
`endif
        step(0, 0, 0, 0, 0, 1);
        check_model("dup");

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            int c, id;
            c  = int'($urandom_range(0, 3));
            id = int'($urandom_range(0, 31));
            if (c < 3 && $urandom_range(0, 3) != 0) id = id % lim[c];
            step(2'(c), 5'(id), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 2, 1'($urandom_range(0, 1)));
            check_model($sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
